// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
//
// Byte-to-serial UART transmitter (8N1 at defaults) with a valid/ready byte
// input. Its tx line feeds the UART receiver/pattern-match block, so the bit
// period comes from the same CLK_FREQ_HZ / BAUD_RATE pair the receiver uses.
//
// Frame on tx: start(0) | d0..d7 (LSB first) | [parity] | stop(1) x STOP_BITS
// Each bit is held for BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE cycles.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_data     byte to transmit, sampled only on the handshake edge
//   in_valid    in_data is valid
//   in_ready    combinational: idle and not in reset
//   tx          serial line, idle high (registered)
//   busy        frame in progress (registered)
//   bit_strobe  one-cycle pulse on the first cycle of every bit (registered)
//   tx_done     one-cycle pulse on the first idle cycle after a frame
// ---------------------------------------------------------------------------
module uart_tx_framer #(
    parameter int CLK_FREQ_HZ = 1_600_000,
    parameter int BAUD_RATE   = 100_000,
    parameter int PARITY      = 0,   // 0 none, 1 even, 2 odd
    parameter int STOP_BITS   = 1    // 1 or 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       bit_strobe,
    output logic       tx_done
);

    localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
    // Guard keeps the width legal even when the divider check below fires.
    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 2);

    // Elaboration-time parameter checks.
    if (BAUD_DIV < 2) begin : g_chk_div
        $error("uart_tx_framer: CLK_FREQ_HZ / BAUD_RATE must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_tx_framer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;       // cycle within the current bit
    logic [2:0]       idx_q, idx_d;       // data bit index, reused for stop bits
    logic [7:0]       shift_q, shift_d;   // shift_q[0] is the bit on the line
    logic             par_q, par_d;       // parity bit, fixed at accept time
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic             bit_end;

    assign in_ready = (state_q == S_IDLE) && !rst;
    assign bit_end  = (cnt_q == CNT_LAST);

    // Next-state logic. Outputs are computed one cycle early so that the
    // registered tx/bit_strobe line up with the first cycle of each bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        if (state_q == S_IDLE) begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (in_valid && in_ready) begin
                state_d  = S_START;
                cnt_d    = '0;
                idx_d    = '0;
                shift_d  = in_data;
                par_d    = (^in_data) ^ PAR_ODD;
                tx_d     = 1'b0;
                busy_d   = 1'b1;
                strobe_d = 1'b1;
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            // Bit boundary: the only place tx may change outside reset.
            cnt_d    = '0;
            strobe_d = 1'b1;
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
                S_DATA: begin
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
                S_PARITY: begin
                    state_d = S_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
                S_STOP: begin
                    if (idx_q == STOP_LAST) begin
                        // Frame complete: first idle cycle carries tx_done.
                        state_d  = S_IDLE;
                        idx_d    = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        strobe_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                    tx_d = 1'b1;
                end
                default: begin
                    state_d  = S_IDLE;
                    idx_d    = '0;
                    tx_d     = 1'b1;
                    busy_d   = 1'b0;
                    strobe_d = 1'b0;
                end
            endcase
        end
    end

    // Reset has priority over a same-edge handshake, so that byte is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign bit_strobe = strobe_q;
    assign tx_done    = done_q;

endmodule
